ram16_arbiter: RTL
==================

// Module: ram16_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of one RAM_16 instance (single port).
//  Accepts read/write commands over a valid/ready handshake and serialises them onto the RAM's
//  WrEn/RdEn/Address/WrData. Returns read data with a per-requester response pulse.
//  Sits between two bus masters and the shared RAM_16 instance; never drives WrEn and RdEn together.
// PARAMETERS
//  Width   16  data width; equals RAM_16 Width
//  Depth   8   RAM words; equals RAM_16 Depth
//  ADD_WD  3   address width; equals RAM_16 ADD_WD
// PORTS
//  CLK          in   1           clock; all logic on rising edge
//  RST          in   1           synchronous reset, active-high
//  req_valid    in   2           bit i: requester i presents a command
//  req_we       in   2           bit i: 1 = write, 0 = read
//  req_addr     in   2*ADD_WD    requester i address at [i*ADD_WD +: ADD_WD]
//  req_wdata    in   2*Width     requester i write data at [i*Width +: Width]
//  req_ready    out  2           bit i: command i accepted this cycle (one-hot or zero)
//  rsp_valid    out  2           bit i: one-cycle pulse, rsp_rdata holds requester i read result
//  rsp_rdata    out  Width       read data, valid only while a rsp_valid bit is high
//  ram_wr_en    out  1           to RAM_16 WrEn
//  ram_rd_en    out  1           to RAM_16 RdEn
//  ram_addr     out  ADD_WD      to RAM_16 Address
//  ram_wr_data  out  Width       to RAM_16 WrData
//  ram_rd_data  in   Width       from RAM_16 RdData; valid the cycle after the edge sampling RdEn=1
// BEHAVIOUR
//  - Reset (RST=1 at edge): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_rdata=0,
//    ram_wr_en=0, ram_rd_en=0, ram_addr=0, ram_wr_data=0. In-flight access dropped, no response.
//    RAM contents untouched.
//  - FSM states IDLE, ISSUE, RDWAIT.
//  - IDLE: req_ready combinational: winner = rr_ptr if req_valid[rr_ptr], else the other if valid.
//    Transfer = req_valid[w] & req_ready[w]. On transfer: latch we/addr/wdata and owner w,
//    load registered ram_wr_en=we, ram_rd_en=~we, ram_addr, ram_wr_data; rr_ptr <= ~w; go to ISSUE.
//    req_ready held 0 in ISSUE/RDWAIT.
//  - ISSUE: RAM controls high for exactly this cycle; cleared at end. Write -> IDLE. Read -> RDWAIT.
//  - RDWAIT: capture ram_rd_data into rsp_rdata; set rsp_valid[owner]=1 for one cycle (next cycle);
//    go to IDLE.
//  - Latency from handshake edge t: write committed at edge t+1; read rsp_valid high in cycle t+3.
//    Peak throughput: 1 write/2 cycles, 1 read/3 cycles.
//  - rsp_valid may coincide with a new IDLE grant; both are legal.
//  - Simultaneous valid: rr_ptr decides; a requester losing once wins the next contention (no starvation).
//  - Single valid requester is granted regardless of rr_ptr; rr_ptr still flips to the other.
//  - Requester must hold command stable while valid & ~ready; deasserting before grant is legal (no access).
//  - Accesses are strictly serialised in grant order: write then read of the same address by the
//    other requester returns the new data.
//  - Address wrap: none; ADD_WD bits cover Depth exactly, passed unmodified.
// STRUCTURE
//  - Package ram16_arb_pkg: state enum (IDLE/ISSUE/RDWAIT) and localparam NREQ=2.
//  - Sub-module rr_arb2: inputs valid[1:0], ptr; output one-hot grant[1:0]; purely combinational.
//  - FSM, command latch, RAM drive registers and response register stay in ram16_arbiter.
// TESTING (bench instantiates ram16_arbiter + RAM_16, period 10)
//  - Reset: RST=1 two cycles mid-read -> all outputs 0, no rsp_valid; the following access is normal.
//  - Req0 write addr 4 data 35, then req0 read addr 4 -> rsp_valid=01 at t+3, rsp_rdata=35.
//  - Both valid same cycle from reset, req0 wr addr1=15, req1 wr addr2=22 -> grants 01 then 10;
//    reads return 15 and 22.
//  - Req1 writes addr 4=99 while req0 reads addr 4 queued behind it -> req0 rsp_rdata=99.
//  - Both hold valid continuously for 8 commands -> grants alternate 01,10,01...; never WrEn&RdEn.
//  - Req0 drops valid before grant -> no RAM strobe; ready never seen with valid low.

Source files
------------

// File: rtl/ram16_arb_pkg.sv
// rtl/ram16_arb_pkg.sv - shared state encoding and requester count for the RAM_16 arbiter
package ram16_arb_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant: ptr has priority, the other wins if ptr is idle
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  logic other;
  assign other = ~ptr;

  always_comb begin
    grant = 2'b00;
    if (valid[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (valid[other]) begin
      grant[other] = 1'b1;
    end
  end

endmodule

// File: rtl/ram16_arbiter.sv
// rtl/ram16_arbiter.sv - serialises two requesters' read/write commands onto one single-port RAM_16
module ram16_arbiter
  import ram16_arb_pkg::*;
#(
  parameter int Width  = 16,
  parameter int Depth  = 8,
  parameter int ADD_WD = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADD_WD-1:0]   req_addr,
  input  logic [NREQ*Width-1:0]    req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [Width-1:0]         rsp_rdata,
  output logic                     ram_wr_en,
  output logic                     ram_rd_en,
  output logic [ADD_WD-1:0]        ram_addr,
  output logic [Width-1:0]         ram_wr_data,
  input  logic [Width-1:0]         ram_rd_data
);

  if (Depth != (1 << ADD_WD)) begin : g_depth_check
    $error("ram16_arbiter: Depth must equal 2**ADD_WD");
  end

  state_t              state;
  logic                rr_ptr;
  logic                owner;
  logic                cmd_we;
  logic [1:0]          grant;
  logic                xfer;
  logic                win;
  logic [ADD_WD-1:0]   sel_addr;
  logic [Width-1:0]    sel_wdata;

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // ready is held low while reset is asserted so no command is accepted into a reset edge
  assign req_ready = (state == IDLE && !RST) ? grant : 2'b00;
  assign xfer      = |req_ready;
  assign win       = req_ready[1];
  assign sel_addr  = win ? req_addr[ADD_WD +: ADD_WD] : req_addr[0 +: ADD_WD];
  assign sel_wdata = win ? req_wdata[Width +: Width]  : req_wdata[0 +: Width];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      cmd_we      <= 1'b0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      ram_wr_en   <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (xfer) begin
            owner       <= win;
            cmd_we      <= req_we[win];
            ram_wr_en   <= req_we[win];
            ram_rd_en   <= ~req_we[win];
            ram_addr    <= sel_addr;
            ram_wr_data <= sel_wdata;
            rr_ptr      <= ~win;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          ram_wr_en <= 1'b0;
          ram_rd_en <= 1'b0;
          state     <= cmd_we ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          // RAM read data is registered, so it is valid in the cycle after the RdEn edge
          rsp_rdata        <= ram_rd_data;
          rsp_valid[owner] <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
